// File: rtl/serial_mag_cmp_ctrl_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding and chunk width.
package serial_mag_cmp_ctrl_pkg;

  localparam int CHUNK_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_mag_cmp_ctrl_cmp2_slice.sv
// Combinational 2-bit unsigned comparator slice reused for every chunk of the serial compare.
module cmp2_slice
  import serial_mag_cmp_ctrl_pkg::*;
(
  input  logic [CHUNK_W-1:0] x,
  input  logic [CHUNK_W-1:0] y,
  output logic               gt2,
  output logic               eq2
);

  assign gt2 = (x > y);
  assign eq2 = (x == y);

endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// Serial WIDTH-bit unsigned magnitude comparator, 2 bits per cycle MSB first, valid/ready on both sides.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing chunk instead of scanning all chunks.
module serial_mag_cmp_ctrl
  import serial_mag_cmp_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             dec_q, dec_d;
  logic             slice_gt, slice_eq;

  cmp2_slice u_slice (
    .x   (sa_q[WIDTH-1 -: CHUNK_W]),
    .y   (sb_q[WIDTH-1 -: CHUNK_W]),
    .gt2 (slice_gt),
    .eq2 (slice_eq)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    dec_d   = dec_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          sa_d    = a;
          sb_d    = b;
          cnt_d   = CW'(N - 1);
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          dec_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Only the most significant differing chunk decides the result.
        if (!slice_eq && !dec_q) begin
          gt_d  = slice_gt;
          lt_d  = !slice_gt;
          dec_d = 1'b1;
        end
        sa_d = sa_q << CHUNK_W;
        sb_d = sb_q << CHUNK_W;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (!slice_eq || cnt_q == '0) state_d = ST_DONE;
        else                          cnt_d   = cnt_q - 1'b1;
`else
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
`endif
        if (state_d == ST_DONE && !dec_d) eq_d = 1'b1;
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      dec_q   <= dec_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign gt          = gt_q;
  assign eq          = eq_q;
  assign lt          = lt_q;

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Randomized self-checking bench for serial_mag_cmp_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_mag_cmp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sv8, sr8, rv8, rr8, gt8, eq8, lt8, busy8;
  logic [7:0] a8, b8;
  logic       sv2, sr2, rv2, rr2, gt2, eq2, lt2, busy2;
  logic [1:0] a2, b2;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_mag_cmp_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8), .a(a8), .b(b8),
    .res_valid(rv8), .res_ready(rr8), .gt(gt8), .eq(eq8), .lt(lt8), .busy(busy8)
  );

  serial_mag_cmp_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(sr2), .a(a2), .b(b2),
    .res_valid(rv2), .res_ready(rr2), .gt(gt2), .eq(eq2), .lt(lt2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Chunks examined: first differing 2-bit chunk from the MSB when exiting early, else all of them.
  function automatic int exp_k(input int av, input int bv, input int n);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = 0; i < n; i++) begin
      if (((av >> (2 * (n - 1 - i))) % 4) != ((bv >> (2 * (n - 1 - i))) % 4)) return i + 1;
    end
`endif
    return n;
  endfunction

  task automatic start8(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    a8 = av; b8 = bv; sv8 = 1'b1;
    @(posedge clk);
    #1;
    sv8 = 1'b0;
    chk("start_busy8", 32'(busy8), 32'd1);
  endtask

  task automatic wait_res8(input logic [7:0] av, input logic [7:0] bv, input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!rv8 && n < 40);
    sv8 = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'(exp_k(int'(av), int'(bv), 4)));
    chk({tag, "_gt"}, 32'(gt8), 32'(av > bv));
    chk({tag, "_eq"}, 32'(eq8), 32'(av == bv));
    chk({tag, "_lt"}, 32'(lt8), 32'(av < bv));
  endtask

  task automatic finish8(input logic [7:0] av, input logic [7:0] bv, input int hold, input string tag);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); rr8 = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, 32'(rv8), 32'd1);
      chk({tag, "_hold_gt"}, 32'(gt8), 32'(av > bv));
      chk({tag, "_hold_srdy"}, 32'(sr8), 32'd0);
    end
    @(negedge clk); rr8 = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ack_vld"}, 32'(rv8), 32'd0);
    chk({tag, "_ack_srdy"}, 32'(sr8), 32'd1);
    chk({tag, "_ack_lt"}, 32'(lt8), 32'(av < bv));
    rr8 = 1'b0;
  endtask

  task automatic txn8(input logic [7:0] av, input logic [7:0] bv, input int hold, input bit junk, input string tag);
    start8(av, bv);
    if (junk) begin
      sv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
    end
    wait_res8(av, bv, tag);
    finish8(av, bv, hold, tag);
  endtask

  task automatic txn2(input logic [1:0] av, input logic [1:0] bv, input string tag);
    int n = 0;
    @(negedge clk);
    a2 = av; b2 = bv; sv2 = 1'b1;
    @(posedge clk); #1;
    sv2 = 1'b0;
    do begin
      @(posedge clk); #1; n++;
    end while (!rv2 && n < 20);
    chk({tag, "_lat"}, 32'(n), 32'd1);
    chk({tag, "_gt"}, 32'(gt2), 32'(av > bv));
    chk({tag, "_eq"}, 32'(eq2), 32'(av == bv));
    chk({tag, "_lt"}, 32'(lt2), 32'(av < bv));
    @(negedge clk); rr2 = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ack_vld"}, 32'(rv2), 32'd0);
    rr2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    rst = 1'b1;
    sv8 = 1'b0; rr8 = 1'b0; a8 = '0; b8 = '0;
    sv2 = 1'b0; rr2 = 1'b0; a2 = '0; b2 = '0;
    #12;
    chk("rst_vld", 32'(rv8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_srdy", 32'(sr8), 32'd1);
    chk("rst_res", 32'({gt8, eq8, lt8}), 32'd0);
    @(negedge clk); rst = 1'b0;

    txn8(8'hA5, 8'hA5, 0, 1'b0, "eq_a5");
    txn8(8'h80, 8'h7F, 0, 1'b1, "gt_80");
    txn8(8'h12, 8'h13, 2, 1'b0, "lt_12");

    // Backpressure with a pending start held during DONE.
    start8(8'hF0, 8'h0F);
    wait_res8(8'hF0, 8'h0F, "bp1");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); sv8 = 1'b1; a8 = 8'h01; b8 = 8'h02; rr8 = 1'b0;
      @(posedge clk); #1;
      chk("bp_vld", 32'(rv8), 32'd1);
      chk("bp_gt", 32'(gt8), 32'd1);
      chk("bp_srdy", 32'(sr8), 32'd0);
    end
    @(negedge clk); rr8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_ack_vld", 32'(rv8), 32'd0);
    chk("bp_ack_srdy", 32'(sr8), 32'd1);
    @(negedge clk); rr8 = 1'b0;
    @(posedge clk); #1;
    sv8 = 1'b0;
    chk("bp_accept_busy", 32'(busy8), 32'd1);
    wait_res8(8'h01, 8'h02, "bp2");
    finish8(8'h01, 8'h02, 0, "bp2");

    // Asynchronous reset in the middle of a compare.
    start8(8'hC3, 8'h3C);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(rv8), 32'd0);
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_res", 32'({gt8, eq8, lt8}), 32'd0);
    @(negedge clk); rst = 1'b0;
    txn8(8'h00, 8'h00, 0, 1'b0, "post_rst");

    txn2(2'd3, 2'd1, "w2_gt");
    txn2(2'd2, 2'd2, "w2_eq");
    txn2(2'd1, 2'd3, "w2_lt");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = {ra[7:4], 4'($urandom)};
        default: rb = 8'($urandom);
      endcase
      txn8(ra, rb, int'($urandom_range(0, 2)), 1'($urandom), "rnd8");
    end
    for (int i = 0; i < 10; i++) txn2(2'($urandom), 2'($urandom), "rnd2");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
